me_search_ctrl: RTL and testbench
=================================

ME_SEARCH_CTRL -- requirements
Module: me_search_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1; one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port init_signal, input, 1, start-search request, sampled only in IDLE.
REQ-004 SHALL have ports R_val / S1_val / S2_val, input, 8 each, memory read data, valid one cycle after the matching address.
REQ-005 SHALL have port addr_R, output, 8, reference-block address {row[3:0], col[3:0]}.
REQ-006 SHALL have ports addr_S1 / addr_S2, output, 10 each, search-window address {sy[4:0], sx[4:0]}.
REQ-007 SHALL have port distance_value, output, 8, best SAD saturated to 8'hFF.
REQ-008 SHALL have ports x_motion / y_motion, output, 4 each, best motion vector.
REQ-009 SHALL have port complete_signal, output, 1, search finished and results valid.

Function
REQ-010 SHALL perform a full search: 16x16 reference block (256 px) over a 32x32 window (1024 px), candidates x,y in 0..15.
REQ-011 SHALL evaluate two candidates per pass: S1 port at (x even, y), S2 port at (x+1, y); 8 passes per y, y outer loop, 128 passes.
REQ-012 SHALL issue per pass 256 pixel addresses, row-major: addr_R={row,col}; addr_S1={y+row, x+col}; addr_S2={y+row, x+1+col}.
REQ-013 SHALL accumulate |R_val-S1_val| and |R_val-S2_val| in two 16-bit accumulators (max 65280, no overflow).
REQ-014 SHALL implement FSM: IDLE -> RUN (init_signal=1) -> RUN for 256 cycles -> DRAIN (1 cycle, last data) -> CMP (1 cycle) -> RUN (next pass) or DONE (after pass 127).
REQ-015 SHALL in CMP replace best on strict less-than only; S1 compared first, so ties keep the earlier scan-order candidate and S1 beats S2.
REQ-016 SHALL initialise best SAD to 16'hFFFF at search start so the first pass always updates.
REQ-017 SHALL assert complete_signal exactly 33025 rising edges after the edge that samples init_signal, i.e. 128 passes x 258 cycles + 1 (macro off).
REQ-018 SHALL, in DONE, hold complete_signal, distance_value, x_motion, y_motion stable until init_signal is sampled, then go to RUN and clear complete_signal the next cycle.
REQ-019 SHALL ignore init_signal in RUN, DRAIN and CMP.
REQ-020 SHALL drive distance_value = (best>255) ? 8'hFF : best[7:0], and update it only in CMP.
REQ-021 SHALL register all outputs; addresses are 0 outside RUN.

Reset
REQ-022 SHALL on rst_n=0, at any time including mid-search, force IDLE; all outputs, accumulators, counters to 0; best SAD to 16'hFFFF.
REQ-023 SHALL require a fresh init_signal after reset release; no partial search resumes.

Configuration
REQ-024 SHALL, with ME_EARLY_TERM_EN defined, leave RUN for DRAIN as soon as both accumulators are >= best SAD, skipping remaining pixels of that pass; the result is identical and only the latency shrinks.
REQ-025 SHALL, without ME_EARLY_TERM_EN, always issue all 256 pixels per pass with fixed latency per REQ-017.

Structure
REQ-026 SHALL take RMEM_MAX=256, SMEM_MAX=1024, SAD_W=16, pixel width and the FSM state enum from shared package me_pkg.
REQ-027 SHALL instantiate sub-module me_sad_acc (abs-diff plus clear/accumulate) twice, once per S port.

Verification
REQ-028 R all 8'h10, S all 8'h10 -> distance_value 0, x=0, y=0, complete_signal at edge 33025.
REQ-029 S = R+8'h40 everywhere except an exact copy of R at x=7, y=9 -> distance 0, x=7, y=9 (S2 path).
REQ-030 R all 0, S all 8'hFF -> best SAD 65280, distance_value 8'hFF, x=0, y=0.
REQ-031 rst_n low at edge 1000 of a search -> all outputs 0 asynchronously; new init_signal -> correct result at edge 33025.
REQ-032 init_signal pulsed again at edge 500 of a search -> ignored, result and latency unchanged.
REQ-033 ME_EARLY_TERM_EN defined, stimulus of REQ-029 -> same result, complete_signal before edge 33025.

Source files
------------

// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation search controller:
// memory geometry, accumulator width, FSM state type and address helpers.
package me_pkg;

    localparam int RMEM_MAX = 256;
    localparam int SMEM_MAX = 1024;
    localparam int SAD_W    = 16;
    localparam int PIX_W    = 8;

    localparam int RADDR_W  = $clog2(RMEM_MAX);
    localparam int SADDR_W  = $clog2(SMEM_MAX);

    // Starting best SAD; above any reachable sum (256 * 255 = 65280).
    localparam logic [SAD_W-1:0] SAD_INIT = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_CMP,
        ST_DONE
    } me_state_e;

    // Search-window address {sy, sx} for candidate origin (y, x) and block pixel (row, col).
    function automatic logic [SADDR_W-1:0] s_addr(input logic [3:0] y, input logic [4:0] x,
                                                  input logic [3:0] row, input logic [3:0] col);
        logic [4:0] sy;
        logic [4:0] sx;
        sy = {1'b0, y} + {1'b0, row};
        sx = x + {1'b0, col};
        return {sy, sx};
    endfunction

    // 8-bit reported distance: saturate anything above 255.
    function automatic logic [7:0] sat8(input logic [SAD_W-1:0] v);
        return (v > SAD_W'(255)) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/me_search_ctrl_if.sv
// Bus between the search controller and its pixel memories / host.
// master: the controller (drives addresses and results).
// slave : memories plus host (drive read data and the start request).
interface me_search_ctrl_if
    import me_pkg::*;
();
    logic                init_signal;
    logic [PIX_W-1:0]    R_val;
    logic [PIX_W-1:0]    S1_val;
    logic [PIX_W-1:0]    S2_val;
    logic [RADDR_W-1:0]  addr_R;
    logic [SADDR_W-1:0]  addr_S1;
    logic [SADDR_W-1:0]  addr_S2;
    logic [7:0]          distance_value;
    logic [3:0]          x_motion;
    logic [3:0]          y_motion;
    logic                complete_signal;

    modport master (
        input  init_signal, R_val, S1_val, S2_val,
        output addr_R, addr_S1, addr_S2,
        output distance_value, x_motion, y_motion, complete_signal
    );

    modport slave (
        output init_signal, R_val, S1_val, S2_val,
        input  addr_R, addr_S1, addr_S2,
        input  distance_value, x_motion, y_motion, complete_signal
    );
endinterface

// File: rtl/me_sad_acc.sv
// Sum-of-absolute-differences accumulator for one candidate stream.
// clr has priority over en so a pass boundary always starts from zero.
module me_sad_acc
    import me_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [PIX_W-1:0] r_pix,
    input  logic [PIX_W-1:0] s_pix,
    output logic [SAD_W-1:0] sad
);

    logic [PIX_W-1:0] diff;
    logic [SAD_W-1:0] acc_reg;

    // Absolute difference of the two pixels, no sign bit needed.
    always_comb begin
        diff = (r_pix >= s_pix) ? (r_pix - s_pix) : (s_pix - r_pix);
    end

    // Clear at pass boundary, otherwise add the difference of valid data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
        end else if (clr) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= acc_reg + {{(SAD_W-PIX_W){1'b0}}, diff};
        end
    end

    assign sad = acc_reg;

endmodule

// File: rtl/me_search_ctrl.sv
// Full-search block-matching controller: 16x16 reference block against a
// 32x32 window, candidate origins x,y in 0..15, two candidates (x, x+1)
// per pass. Memory reads have one cycle of latency, so accumulation runs
// two cycles behind the address stream; DRAIN absorbs the tail.
// Optional feature macro: ME_EARLY_TERM_EN -- abandon a pass once both
// partial sums already reach the best SAD (result unchanged, faster).
module me_search_ctrl
    import me_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    me_search_ctrl_if.master  bus
);

    me_state_e          state_reg;
    logic [7:0]         pix_reg;        // pixel index currently on the address bus
    logic [3:0]         cy_reg;         // candidate row
    logic [2:0]         cxp_reg;        // candidate pair index, x = 2*cxp (+1 for S2)
    logic               data_valid_reg; // read data on the bus this cycle belongs to the pass
    logic [SAD_W-1:0]   best_reg;
    logic [3:0]         x_motion_reg;
    logic [3:0]         y_motion_reg;
    logic [7:0]         distance_reg;
    logic               complete_reg;
    logic [RADDR_W-1:0] addr_r_reg;
    logic [SADDR_W-1:0] addr_s1_reg;
    logic [SADDR_W-1:0] addr_s2_reg;

    logic [SAD_W-1:0]   sad1;
    logic [SAD_W-1:0]   sad2;
    logic               acc_clr;
    logic               early_stop;

    logic [SAD_W-1:0]   cmp_best;
    logic [3:0]         cmp_x;
    logic [3:0]         cmp_y;
    logic [7:0]         pix_nxt;
    logic [2:0]         cxp_nxt;
    logic [3:0]         cy_nxt;
    logic               last_pass;

    // Accumulators restart at the end of every compare cycle.
    assign acc_clr = (state_reg == ST_CMP);

    me_sad_acc u_acc_s1 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (acc_clr),
        .en    (data_valid_reg),
        .r_pix (bus.R_val),
        .s_pix (bus.S1_val),
        .sad   (sad1)
    );

    me_sad_acc u_acc_s2 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (acc_clr),
        .en    (data_valid_reg),
        .r_pix (bus.R_val),
        .s_pix (bus.S2_val),
        .sad   (sad2)
    );

`ifdef ME_EARLY_TERM_EN
    // Sums only grow, so once both reach the best this pass cannot win.
    assign early_stop = (sad1 >= best_reg) && (sad2 >= best_reg);
`else
    assign early_stop = 1'b0;
`endif

    // Best-candidate update: S1 first, strict less-than, so earlier scan order wins ties.
    always_comb begin
        cmp_best = best_reg;
        cmp_x    = x_motion_reg;
        cmp_y    = y_motion_reg;
        if (sad1 < cmp_best) begin
            cmp_best = sad1;
            cmp_x    = {cxp_reg, 1'b0};
            cmp_y    = cy_reg;
        end
        if (sad2 < cmp_best) begin
            cmp_best = sad2;
            cmp_x    = {cxp_reg, 1'b1};
            cmp_y    = cy_reg;
        end
    end

    // Next pixel and next candidate pair in scan order (x inner, y outer).
    always_comb begin
        pix_nxt   = pix_reg + 8'd1;
        cxp_nxt   = cxp_reg + 3'd1;
        cy_nxt    = (cxp_reg == 3'd7) ? (cy_reg + 4'd1) : cy_reg;
        last_pass = (cxp_reg == 3'd7) && (cy_reg == 4'd15);
    end

    // Search sequencer with registered addresses and results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            pix_reg        <= '0;
            cy_reg         <= '0;
            cxp_reg        <= '0;
            data_valid_reg <= 1'b0;
            best_reg       <= SAD_INIT;
            x_motion_reg   <= '0;
            y_motion_reg   <= '0;
            distance_reg   <= '0;
            complete_reg   <= 1'b0;
            addr_r_reg     <= '0;
            addr_s1_reg    <= '0;
            addr_s2_reg    <= '0;
        end else begin
            data_valid_reg <= (state_reg == ST_RUN);
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (bus.init_signal) begin
                        // Fresh search: pixel 0 of candidates (0,0) and (1,0).
                        state_reg    <= ST_RUN;
                        pix_reg      <= '0;
                        cy_reg       <= '0;
                        cxp_reg      <= '0;
                        best_reg     <= SAD_INIT;
                        complete_reg <= 1'b0;
                        addr_r_reg   <= '0;
                        addr_s1_reg  <= s_addr(4'd0, 5'd0, 4'd0, 4'd0);
                        addr_s2_reg  <= s_addr(4'd0, 5'd1, 4'd0, 4'd0);
                    end else if (state_reg == ST_DONE) begin
                        complete_reg <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if ((pix_reg == 8'hFF) || early_stop) begin
                        state_reg   <= ST_DRAIN;
                        pix_reg     <= '0;
                        addr_r_reg  <= '0;
                        addr_s1_reg <= '0;
                        addr_s2_reg <= '0;
                    end else begin
                        pix_reg     <= pix_nxt;
                        addr_r_reg  <= pix_nxt;
                        addr_s1_reg <= s_addr(cy_reg, {1'b0, cxp_reg, 1'b0}, pix_nxt[7:4], pix_nxt[3:0]);
                        addr_s2_reg <= s_addr(cy_reg, {1'b0, cxp_reg, 1'b1}, pix_nxt[7:4], pix_nxt[3:0]);
                    end
                end
                ST_DRAIN: begin
                    state_reg <= ST_CMP;
                end
                ST_CMP: begin
                    best_reg     <= cmp_best;
                    x_motion_reg <= cmp_x;
                    y_motion_reg <= cmp_y;
                    distance_reg <= sat8(cmp_best);
                    if (last_pass) begin
                        state_reg <= ST_DONE;
                    end else begin
                        state_reg   <= ST_RUN;
                        cxp_reg     <= cxp_nxt;
                        cy_reg      <= cy_nxt;
                        pix_reg     <= '0;
                        addr_r_reg  <= '0;
                        addr_s1_reg <= s_addr(cy_nxt, {1'b0, cxp_nxt, 1'b0}, 4'd0, 4'd0);
                        addr_s2_reg <= s_addr(cy_nxt, {1'b0, cxp_nxt, 1'b1}, 4'd0, 4'd0);
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.addr_R          = addr_r_reg;
    assign bus.addr_S1         = addr_s1_reg;
    assign bus.addr_S2         = addr_s2_reg;
    assign bus.distance_value  = distance_reg;
    assign bus.x_motion        = x_motion_reg;
    assign bus.y_motion        = y_motion_reg;
    assign bus.complete_signal = complete_reg;

endmodule

// File: tb/tb_me_search_ctrl.sv
// Bench for me_search_ctrl: synchronous pixel memories with one cycle of
// read latency, a brute-force full-search reference, and three searches
// (random R with a planted copy plus an ignored init pulse, a search
// aborted by reset, and a saturating all-0 vs all-FF search).
module tb_me_search_ctrl;

    logic clk;
    logic rst_n;

    me_search_ctrl_if bus ();

    me_search_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] rmem [256];
    logic [7:0] smem [1024];

    int n_checks;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pixel memories: data for an address appears one cycle later.
    always @(posedge clk) begin
        bus.R_val  <= rmem[bus.addr_R];
        bus.S1_val <= smem[bus.addr_S1];
        bus.S2_val <= smem[bus.addr_S2];
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: exhaustive search, scan order y outer / x inner, strict improvement.
    task automatic ref_search(output int sad, output int bx, output int by);
        int best;
        best = 1 << 30;
        bx = 0;
        by = 0;
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 16; x++) begin
                int s;
                s = 0;
                for (int r = 0; r < 16; r++) begin
                    for (int c = 0; c < 16; c++) begin
                        int a;
                        int b;
                        a = rmem[r*16 + c];
                        b = smem[(y + r)*32 + (x + c)];
                        s += (a > b) ? (a - b) : (b - a);
                    end
                end
                if (s < best) begin
                    best = s;
                    bx = x;
                    by = y;
                end
            end
        end
        sad = best;
    endtask

    // Start a search and count edges until complete_signal (or an abort).
    task automatic run_search(input int pulse_at, input int abort_at, output int lat);
        lat = -1;
        @(negedge clk);
        bus.init_signal = 1'b1;
        @(posedge clk);
        #1;
        bus.init_signal = 1'b0;
        check_eq("complete_low_after_start", int'(bus.complete_signal), 0);
        for (int n = 1; n <= 40000; n++) begin
            if (n == pulse_at) bus.init_signal = 1'b1;
            @(posedge clk);
            #1;
            bus.init_signal = 1'b0;
            if (n == abort_at) begin
                rst_n = 1'b0;
                lat = n;
                break;
            end
            if (bus.complete_signal) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int e_sad;
        int e_x;
        int e_y;
        int e_dist;

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.init_signal = 1'b0;
        for (int i = 0; i < 256; i++)  rmem[i] = 8'h00;
        for (int i = 0; i < 1024; i++) smem[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_complete", int'(bus.complete_signal), 0);
        check_eq("rst_distance", int'(bus.distance_value), 0);
        check_eq("rst_x", int'(bus.x_motion), 0);
        check_eq("rst_y", int'(bus.y_motion), 0);
        check_eq("rst_addr_S1", int'(bus.addr_S1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Search 1: random R, window = tiled R + 0x40, exact copy at x=7, y=9.
        for (int i = 0; i < 256; i++) rmem[i] = 8'($urandom_range(0, 255));
        for (int sy = 0; sy < 32; sy++)
            for (int sx = 0; sx < 32; sx++)
                smem[sy*32 + sx] = rmem[(sy % 16)*16 + (sx % 16)] + 8'h40;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                smem[(9 + r)*32 + (7 + c)] = rmem[r*16 + c];
        ref_search(e_sad, e_x, e_y);
        e_dist = (e_sad > 255) ? 255 : e_sad;
        run_search(500, 0, lat);
        $display("search 1: latency %0d dist %0d x %0d y %0d (model sad %0d x %0d y %0d)",
                 lat, bus.distance_value, bus.x_motion, bus.y_motion, e_sad, e_x, e_y);
`ifdef ME_EARLY_TERM_EN
        check_eq("s1_latency_early", int'(lat > 0 && lat < 33025), 1);
`else
        check_eq("s1_latency", lat, 33025);
`endif
        check_eq("s1_distance", int'(bus.distance_value), e_dist);
        check_eq("s1_x", int'(bus.x_motion), e_x);
        check_eq("s1_y", int'(bus.y_motion), e_y);

        // Results hold in DONE while init stays low; addresses idle at 0.
        repeat (5) @(posedge clk);
        #1;
        check_eq("s1_hold_complete", int'(bus.complete_signal), 1);
        check_eq("s1_hold_x", int'(bus.x_motion), e_x);
        check_eq("s1_hold_y", int'(bus.y_motion), e_y);
        check_eq("done_addr_S2", int'(bus.addr_S2), 0);

        // Search 2: restart from DONE with the saturating pattern, reset at edge 1000.
        for (int i = 0; i < 256; i++)  rmem[i] = 8'h00;
        for (int i = 0; i < 1024; i++) smem[i] = 8'hFF;
        run_search(0, 1000, lat);
        #1;
        $display("search 2: aborted by reset at edge %0d", lat);
        check_eq("abort_edge", lat, 1000);
        check_eq("abort_complete", int'(bus.complete_signal), 0);
        check_eq("abort_distance", int'(bus.distance_value), 0);
        check_eq("abort_x", int'(bus.x_motion), 0);
        check_eq("abort_y", int'(bus.y_motion), 0);
        check_eq("abort_addr_R", int'(bus.addr_R), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("no_resume_complete", int'(bus.complete_signal), 0);

        // Search 3: R all 0, S all FF -> best 65280 saturates to 0xFF at (0,0).
        ref_search(e_sad, e_x, e_y);
        e_dist = (e_sad > 255) ? 255 : e_sad;
        run_search(0, 0, lat);
        $display("search 3: latency %0d dist %0d x %0d y %0d (model sad %0d x %0d y %0d)",
                 lat, bus.distance_value, bus.x_motion, bus.y_motion, e_sad, e_x, e_y);
        check_eq("s3_latency", lat, 33025);
        check_eq("s3_distance", int'(bus.distance_value), e_dist);
        check_eq("s3_x", int'(bus.x_motion), e_x);
        check_eq("s3_y", int'(bus.y_motion), e_y);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
